division_unit: RTL and testbench
================================

# division_unit

Multi-cycle integer divider for the CPU's DIV/DIVU instructions, the inverse companion to the shift-add multiplier. It takes a dividend and divisor from the register file and produces the quotient in LO and the remainder in HI. It uses a restoring shift-subtract algorithm, one quotient bit per clock. The control unit starts it with a single-cycle request and stalls on `busy` until `done`.

## Interface
- WIDTH, 32, operand and result width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clock clock
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  in  WIDTH  numerator; sampled with start
- divisor  in  WIDTH  denominator; sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  high exactly one cycle (state DONE); HI/LO/div_zero valid
- div_zero  out  1  last accepted operation had divisor == 0
- hi  out  WIDTH  remainder, registered, held until next result
- lo  out  WIDTH  quotient, registered, held until next result
- state_out  out  2  IDLE=0, CALC=1, FIXUP=2, DONE=3

## Operation
- Reset: state IDLE; hi, lo, div_zero, internal rem/quot/divisor/counter/sign flags = 0; busy = done = 0.
- IDLE, start=0: hold.
- IDLE, start=1, divisor == 0:
  - div_zero <= 1, hi <= dividend, lo <= all-ones; both written raw, independent of is_signed.
  - Go to DONE.
- IDLE, start=1, divisor != 0:
  - div_zero <= 0.
  - quot_neg <= is_signed & (dividend[MSB] ^ divisor[MSB]).
  - rem_neg <= is_signed & dividend[MSB].
  - quot <= |dividend|, dmag <= |divisor|; magnitudes are two's-complement negation when is_signed and MSB set, else raw.
  - rem <= 0, counter <= 0. Go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem, quot} left 1.
  - trial = shifted_rem - dmag, computed WIDTH+1 bits wide.
  - If no borrow: rem <= trial and quot[0] <= 1; else rem <= shifted_rem and quot[0] <= 0.
  - counter <= counter + 1.
  - After the iteration with counter == WIDTH-1, go to FIXUP.
- FIXUP: lo <= quot_neg ? -quot : quot; hi <= rem_neg ? -rem : rem. Go to DONE.
- DONE: done=1; unconditionally return to IDLE.
- Sign rules: the remainder takes the dividend's sign; the quotient truncates toward zero.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): magnitudes give quot 0x80000000 with quot_neg=0, so lo=0x80000000, hi=0. No special-case logic.
- start while busy (CALC/FIXUP/DONE) is ignored; operands are not re-sampled.
- hi/lo change only in FIXUP, on the divide-by-zero start, and on reset.

## Timing
- Start accepted on edge E0. CALC iterations occur on edges E1..E32 (WIDTH=32). FIXUP writes hi/lo on E33.
- done is high between E33 and E34. IDLE at E34; next start can be accepted on E34. Latency: WIDTH+2 edges from acceptance to done.
- Divide by zero: hi/lo/div_zero written on E0; done high between E0 and E1; IDLE at E1.
- busy rises immediately after E0 and falls after leaving DONE.
- Reset mid-operation (any state) returns to IDLE immediately and clears all outputs; no done pulse. The aborted operation is lost.
- done is decoded from state, with no combinational path from inputs.

## Test plan
- DIVU 100 / 7 -> after 34 edges done=1, lo=14, hi=2, div_zero=0; busy high for 34 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
- Divide by zero, 0x12345678 / 0 (both signednesses) -> done one cycle after start, div_zero=1, lo=0xFFFFFFFF, hi=0x12345678. A following valid op clears div_zero.
- Start 100/7, re-pulse start with 9/3 at cycle 5 and in DONE -> the second request is ignored and the result is lo=14, hi=2. Back-to-back start on the IDLE cycle is accepted with correct result.
- Reset asserted during the 10th CALC cycle -> state_out=0, hi=lo=0, busy=done=0 immediately, no done pulse. A subsequent DIVU 50/5 gives lo=10, hi=0.

Source files
------------

// File: rtl/division_unit_if.sv
// Request/result bundle between the control unit and the divider.
// The control unit drives the operands and start; the divider returns status and results.
interface division_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state_out;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_zero, hi, lo, state_out
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_zero, hi, lo, state_out
  );
endinterface

// File: rtl/division_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock.
// Works on magnitudes and applies the result signs in a final fixup cycle.
// Quotient lands in lo, remainder in hi.
module division_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  division_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] dmag_reg, dmag_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic             quot_neg_reg, quot_neg_next;
  logic             rem_neg_reg, rem_neg_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             div_zero_reg, div_zero_next;

  // Operand magnitudes: only negate when the signed form is requested and the value is negative.
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  assign dividend_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign divisor_mag  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // Partial remainder shifted left by one with the next dividend bit pulled in.
  // One extra bit keeps the unsigned case exact; trial[WIDTH] is the borrow.
  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] trial;
  assign shifted_rem = {rem_reg, quot_reg[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, dmag_reg};

  // State, datapath and result registers; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      quot_reg     <= '0;
      dmag_reg     <= '0;
      counter_reg  <= '0;
      quot_neg_reg <= 1'b0;
      rem_neg_reg  <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      quot_reg     <= quot_next;
      dmag_reg     <= dmag_next;
      counter_reg  <= counter_next;
      quot_neg_reg <= quot_neg_next;
      rem_neg_reg  <= rem_neg_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      div_zero_reg <= div_zero_next;
    end
  end

  // Next-state and datapath updates for each phase of the division.
  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    quot_next     = quot_reg;
    dmag_next     = dmag_reg;
    counter_next  = counter_reg;
    quot_neg_next = quot_neg_reg;
    rem_neg_next  = rem_neg_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    div_zero_next = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide by zero is reported immediately with raw operands, no iteration.
            div_zero_next = 1'b1;
            hi_next       = bus.dividend;
            lo_next       = '1;
            state_next    = DONE;
          end else begin
            div_zero_next = 1'b0;
            quot_neg_next = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            rem_neg_next  = bus.is_signed & bus.dividend[WIDTH-1];
            quot_next     = dividend_mag;
            dmag_next     = divisor_mag;
            rem_next      = '0;
            counter_next  = '0;
            state_next    = CALC;
          end
        end
      end
      CALC: begin
        // Keep the subtraction only when it did not borrow (restoring step).
        rem_next     = trial[WIDTH] ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_next    = {quot_reg[WIDTH-2:0], ~trial[WIDTH]};
        counter_next = counter_reg + 1'b1;
        if (counter_reg == LAST_ITER) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo_next    = quot_neg_reg ? -quot_reg : quot_reg;
        hi_next    = rem_neg_reg  ? -rem_reg  : rem_reg;
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.div_zero  = div_zero_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
  assign bus.state_out = state_reg;
endmodule

// File: tb/tb_division_unit.sv
// Self-checking bench for division_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_division_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  division_unit_if #(.WIDTH(32)) bus ();

  division_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: 64-bit arithmetic gives truncating division with remainder of dividend's sign.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      z = 1'b1;
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      z = 1'b0;
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue one operation from a negedge, wait for done, check latency, busy and results.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          n;
    int          exp_lat;
    logic        busy_ok;
    ref_div(sgn, a, b, eq, er, ez);
    exp_lat = ez ? 0 : 33;
    bus.start = 1'b1;
    bus.is_signed = sgn;
    bus.dividend = a;
    bus.divisor = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy"}, 32'({busy_ok, bus.busy}), 32'd3);
    check({tag, "_lo"}, bus.lo, eq);
    check({tag, "_hi"}, bus.hi, er);
    check({tag, "_divzero"}, 32'(bus.div_zero), 32'(ez));
    $display("op %s signed=%0d a=%h b=%h -> lo=%h hi=%h dz=%0d cycles=%0d",
             tag, sgn, a, b, bus.lo, bus.hi, bus.div_zero, n);
    tick();
    check({tag, "_idle"}, 32'({bus.state_out, bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    int          n;
    logic        saw_done;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_state", 32'(bus.state_out), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_flags", 32'({bus.busy, bus.done, bus.div_zero}), 32'd0);
    reset = 1'b0;
    tick();

    // Directed cases
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("divu_zero", 1'b0, 32'h1234_5678, 32'd0);
    run_op("div_zero", 1'b1, 32'h1234_5678, 32'd0);
    run_op("clear_dz", 1'b0, 32'd9, 32'd3);

    // Start re-pulsed mid-calculation and during DONE must be ignored.
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.start = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    tick();
    bus.start = 1'b0;
    n = 6;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check("ignore_latency", 32'(n), 32'd33);
    bus.start = 1'b1;
    check("ignore_lo", bus.lo, 32'd14);
    check("ignore_hi", bus.hi, 32'd2);
    tick();
    bus.start = 1'b0;
    check("ignore_done_idle", 32'({bus.state_out, bus.busy}), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("ignore_no_restart", 32'(saw_done), 32'd0);
    $display("op ignore_restart lo=%h hi=%h", bus.lo, bus.hi);

    // Back-to-back operations, each started on the first IDLE cycle.
    run_op("b2b_1", 1'b0, 32'd1000, 32'd10);
    run_op("b2b_2", 1'b1, 32'hFFFF_FC18, 32'd7);

    // Reset during the 10th CALC cycle.
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd12345;
    bus.divisor = 32'd17;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("pre_rst_calc", 32'(bus.state_out), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(bus.state_out), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_flags", 32'({bus.busy, bus.done, bus.div_zero}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    $display("op reset_abort state=%0d", bus.state_out);
    run_op("after_rst", 1'b0, 32'd50, 32'd5);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), sgn, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
